lsu_mem_port: RTL and testbench
===============================

// Module: lsu_mem_port
// PURPOSE
//  Memory-side responder for the load/store control issued by the decode/control unit.
//  - Accepts one load or store per transaction: size code (op_PMEM) and sign-extension code (op_load_sext).
//  - Drives a word-aligned data-memory bus with byte-lane masks and waits for the memory ack.
//  - Returns aligned, sign/zero-extended load data to the register write-back path.
// PARAMETERS
//  TIMEOUT_CYC  16  cycles in ACCESS without mem_ack before the access is aborted with an error; 0 disables the timeout
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   synchronous reset, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   block can accept a request (high only in IDLE)
//  req_load    in   1   load request (load from control unit)
//  req_store   in   1   store request (store from control unit)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, LSB-justified
//  req_size    in   8   op_PMEM size code: `BYTE / `HALF_WORD / `WORD
//  req_sext    in   2   00 zero-ext, 01 sign-ext byte, 10 sign-ext half, 11 treated as 00
//  resp_valid  out  1   one-cycle response pulse; no back-pressure
//  resp_rdata  out  32  extended load data (0 for stores and for errors)
//  resp_err    out  1   qualifies resp_valid: access failed
//  mem_req     out  1   bus request, held until mem_ack
//  mem_we      out  1   1 = write
//  mem_addr    out  32  {req_addr[31:2],2'b00}
//  mem_wdata   out  32  req_wdata << 8*req_addr[1:0]
//  mem_wmask   out  4   byte-lane enables (writes only, 0 on reads)
//  mem_ack     in   1   access complete; mem_rdata valid in the same cycle
//  mem_rdata   in   32  read word
// BEHAVIOUR
//  - States: IDLE, ACCESS, RESP.
//  - Reset values: state = IDLE; req_ready = 0 while rst is high; every other output = 0.
//  - IDLE: req_ready = 1.
//    - req_valid with exactly one of load/store: latch all request fields -> ACCESS.
//    - load and store both set: no bus access; resp_err = 1 -> RESP.
//    - Neither set: request ignored; stay in IDLE.
//  - ACCESS: mem_req = 1 with stable addr/we/wdata/wmask.
//    - On mem_ack: capture the response -> RESP.
//    - Cycle counter cleared on entry. Counter reaching TIMEOUT_CYC without ack: drop mem_req; resp_err = 1 -> RESP.
//  - RESP: resp_valid = 1 for exactly one cycle -> IDLE.
//    - resp_rdata and resp_err are registered and hold until the next response.
//  - Latency: accept at cycle 0, mem_req from cycle 1, ack at cycle M >= 1, resp_valid at M+1, req_ready again at M+2.
//  - Size mask: BYTE = 4'b0001, HALF_WORD = 4'b0011, WORD = 4'b1111; any other code behaves as BYTE.
//    - wmask = (size mask << addr[1:0]), truncated to 4 bits.
//  - Load data: (mem_rdata >> 8*addr[1:0]) masked to the size, then extended per req_sext.
//  - mem_ack outside ACCESS is ignored. Late ack after a timeout or reset is ignored.
//  - rst in any state: IDLE on the next edge; mem_req drops; no resp_valid for the aborted access.
// CONFIGURATION
//  - MISALIGN_CHECK_EN defined:
//    - Misaligned access (HALF_WORD with addr[0] = 1, or WORD with addr[1:0] != 0) is not issued.
//    - Goes IDLE -> RESP with resp_err = 1 and resp_rdata = 0.
//  - MISALIGN_CHECK_EN undefined:
//    - Misaligned access is issued as-is; lanes shifted past byte 3 are dropped.
//    - resp_err comes only from timeout or load+store conflict.
// STRUCTURE
//  - Shared TYPES.v holds the `BYTE/`HALF_WORD/`WORD size codes, the sext codes and the LSU_IDLE/ACCESS/RESP state encodings.
//  - One combinational sub-module, lsu_lane_align: computes wmask, wdata shift, read shift and extension from addr[1:0], size and sext.
//  - The FSM, latches and timeout counter live in lsu_mem_port.
// TESTING
//  1. Load word: addr 0x80000004, WORD, ack at cycle 3, rdata 0xDEADBEEF
//     -> mem_addr 0x80000004, wmask 0, resp_valid at cycle 4, rdata 0xDEADBEEF, err 0.
//  2. Load byte: addr 0x80000003, BYTE, sext 01, rdata 0x80112233
//     -> resp_rdata 0xFFFFFF80. Same access with sext 00 -> 0x00000080.
//  3. Store half: addr 0x80000002, HALF_WORD, wdata 0x0000ABCD
//     -> mem_we 1, wmask 4'b1100, wdata 0xABCD0000, resp_valid with rdata 0.
//  4. Timeout: no ack, TIMEOUT_CYC = 16
//     -> mem_req high for 16 cycles then low; resp_valid with err 1; an ack 2 cycles later is ignored.
//  5. rst asserted in ACCESS
//     -> IDLE next edge, mem_req 0, no resp_valid; the next request completes normally.
//  6. WORD at 0x80000001
//     -> with MISALIGN_CHECK_EN: no mem_req, resp err 1 one cycle after accept.
//     -> without it: wmask 4'b1110, err 0.

Source files
------------

// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_port_pkg
//   Shared types for the load/store memory port: op_PMEM size codes,
//   sign-extension codes, FSM state encoding, the latched request record
//   and small helpers for lane masks and alignment.
package lsu_mem_port_pkg;

    // op_PMEM size codes
    localparam logic [7:0] SZ_BYTE      = 8'h00;
    localparam logic [7:0] SZ_HALF_WORD = 8'h01;
    localparam logic [7:0] SZ_WORD      = 8'h02;

    // op_load_sext codes (2'b11 behaves as zero-extend)
    localparam logic [1:0] SEXT_NONE = 2'b00;
    localparam logic [1:0] SEXT_BYTE = 2'b01;
    localparam logic [1:0] SEXT_HALF = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  size;
        logic [1:0]  sext;
    } lsu_req_t;

    // Byte-lane mask of an access at offset 0; unknown codes act as BYTE.
    function automatic logic [3:0] size_mask(input logic [7:0] size);
        case (size)
            SZ_HALF_WORD: return 4'b0011;
            SZ_WORD:      return 4'b1111;
            default:      return 4'b0001;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [7:0] size, input logic [1:0] off);
        case (size)
            SZ_HALF_WORD: return off[0];
            SZ_WORD:      return off != 2'b00;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if
//   Request/response handshake with the control unit plus the word-aligned
//   data-memory bus.
//   slave  : the LSU memory port (accepts requests, drives the memory bus)
//   master : the environment (control unit + memory model)
interface lsu_mem_port_if;
    // control-unit request
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [7:0]  req_size;
    logic [1:0]  req_sext;
    // write-back response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    // data-memory bus
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_load, req_store, req_addr, req_wdata, req_size, req_sext,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ack, mem_rdata
    );

    modport master (
        output req_valid, req_load, req_store, req_addr, req_wdata, req_size, req_sext,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_port_lane_align.sv
// lsu_lane_align
//   Combinational byte-lane steering for one access.
//   off/size/sext/we : latched access attributes
//   wdata  -> wdata_sh  : store data moved up to its byte lane
//   wmask              : write lane enables (0 for reads); lanes past byte 3 drop
//   rdata  -> rdata_ext : read word shifted down, masked to size, then extended
module lsu_lane_align
    import lsu_mem_port_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [7:0]  size,
    input  logic [1:0]  sext,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);
    logic [31:0] rd_sh;
    logic [31:0] rd_msk;

    always_comb begin
        wmask    = we ? (size_mask(size) << off) : 4'b0000;
        wdata_sh = wdata << {off, 3'b000};
        rd_sh    = rdata >> {off, 3'b000};

        case (size)
            SZ_HALF_WORD: rd_msk = {16'h0000, rd_sh[15:0]};
            SZ_WORD:      rd_msk = rd_sh;
            default:      rd_msk = {24'h000000, rd_sh[7:0]};
        endcase

        // Extension width follows the sext code, not the size code.
        case (sext)
            SEXT_BYTE: rdata_ext = {{24{rd_msk[7]}}, rd_msk[7:0]};
            SEXT_HALF: rdata_ext = {{16{rd_msk[15]}}, rd_msk[15:0]};
            default:   rdata_ext = rd_msk;
        endcase
    end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port
//   Memory-side responder for load/store requests from the control unit.
//   Latches one request, drives a word-aligned memory access until mem_ack
//   (or timeout), then pulses a one-cycle response with extended load data.
//   Ports: clk, rst (sync, active-high), bus (lsu_mem_port_if.slave).
//   Parameter: TIMEOUT_CYC - ACCESS cycles without ack before erroring out;
//              0 disables the timeout.
//   Build option: MISALIGN_CHECK_EN - reject misaligned HALF_WORD/WORD
//              accesses with an error instead of issuing them.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
)(
    input logic           clk,
    input logic           rst,
    lsu_mem_port_if.slave bus
);
    localparam bit TO_EN = (TIMEOUT_CYC > 0);

    lsu_state_e  state;
    lsu_req_t    cur;
    logic [15:0] cyc_cnt;
    logic [31:0] rdata_ext;
    logic [31:0] wdata_sh;
    logic [3:0]  wmask;
    logic        accept, one_op, conflict, bad_align, timeout_hit;

    lsu_lane_align u_align (
        .off      (cur.addr[1:0]),
        .size     (cur.size),
        .sext     (cur.sext),
        .we       (cur.we),
        .wdata    (cur.wdata),
        .rdata    (bus.mem_rdata),
        .wmask    (wmask),
        .wdata_sh (wdata_sh),
        .rdata_ext(rdata_ext)
    );

    // Bus address/data come straight from the latched request, so they are
    // stable for the whole ACCESS phase.
    assign bus.mem_we    = cur.we;
    assign bus.mem_addr  = {cur.addr[31:2], 2'b00};
    assign bus.mem_wdata = wdata_sh;
    assign bus.mem_wmask = wmask;

    assign accept   = bus.req_valid && bus.req_ready;
    assign one_op   = bus.req_load ^ bus.req_store;
    assign conflict = bus.req_load & bus.req_store;

`ifdef MISALIGN_CHECK_EN
    assign bad_align = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    assign timeout_hit = TO_EN && (cyc_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LSU_IDLE;
            cur            <= '0;
            cyc_cnt        <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.mem_req    <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (accept) begin
                        if (conflict || (one_op && bad_align)) begin
                            // rejected without touching the bus
                            bus.req_ready  <= 1'b0;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                            state          <= LSU_RESP;
                        end else if (one_op) begin
                            bus.req_ready <= 1'b0;
                            bus.mem_req   <= 1'b1;
                            cyc_cnt       <= '0;
                            cur           <= '{we:    bus.req_store,
                                               addr:  bus.req_addr,
                                               wdata: bus.req_wdata,
                                               size:  bus.req_size,
                                               sext:  bus.req_sext};
                            state         <= LSU_ACCESS;
                        end
                    end
                end
                LSU_ACCESS: begin
                    // ack wins over a timeout landing in the same cycle
                    if (bus.mem_ack) begin
                        bus.mem_req    <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= cur.we ? 32'h0 : rdata_ext;
                        state          <= LSU_RESP;
                    end else if (timeout_hit) begin
                        bus.mem_req    <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= '0;
                        state          <= LSU_RESP;
                    end else if (TO_EN) begin
                        cyc_cnt <= cyc_cnt + 16'd1;
                    end
                end
                LSU_RESP: begin
                    bus.req_ready <= 1'b1;
                    state         <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port
//   Randomized + directed bench for lsu_mem_port against a byte-arithmetic
//   reference model. Honors MISALIGN_CHECK_EN the same way the design does.
module tb_lsu_mem_port;
    import lsu_mem_port_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lsu_mem_port_if bus();

    lsu_mem_port #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [7:0] sz);
        return (sz == SZ_HALF_WORD) ? 2 : (sz == SZ_WORD) ? 4 : 1;
    endfunction

    function automatic logic [3:0] exp_mask(input bit st, input logic [31:0] a, input logic [7:0] sz);
        int m;
        m = (1 << nbytes(sz)) - 1;
        m = (m << a[1:0]) % 16;
        return st ? 4'(m) : 4'd0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [31:0] rd,
                                             input logic [7:0] sz, input logic [1:0] sx);
        longint v;
        v = longint'(rd) / (longint'(1) << (8 * a[1:0]));
        v = v % (longint'(1) << (8 * nbytes(sz)));
        if (sx == 2'b01) begin
            v = v % 256;
            if (v >= 128) v = v - 256;
        end else if (sx == 2'b10) begin
            v = v % 65536;
            if (v >= 32768) v = v - 65536;
        end
        return v[31:0];
    endfunction

    function automatic bit exp_misalign(input logic [31:0] a, input logic [7:0] sz);
`ifdef MISALIGN_CHECK_EN
        return (nbytes(sz) > 1) && ((a % nbytes(sz)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 8; i++) begin
            if (bus.req_ready) break;
            step();
        end
        if (!bus.req_ready) chk("ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic drive_req(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] wd,
                             input logic [7:0] sz, input logic [1:0] sx);
        bus.req_valid = 1'b1;
        bus.req_load  = ld;
        bus.req_store = st;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_size  = sz;
        bus.req_sext  = sx;
        step();
        bus.req_valid = 1'b0;
        bus.req_load  = 1'b0;
        bus.req_store = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
    endtask

    // ack_at: cycle (after accept) in which mem_ack is driven; 0 = never
    task automatic run_txn(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] wd,
                           input logic [7:0] sz, input logic [1:0] sx, input int ack_at,
                           input logic [31:0] rd);
        bit          imm_err, to;
        int          cyc, req_cnt, exp_cyc;
        bit          got;
        logic [31:0] exp_rd;

        imm_err = (ld && st) || exp_misalign(a, sz);
        to      = (ack_at == 0) || (ack_at > TO);
        exp_rd  = (imm_err || to || st) ? 32'h0 : exp_load(a, rd, sz, sx);

        wait_ready();
        drive_req(ld, st, a, wd, sz, sx);
        cyc = 1;

        if (imm_err) begin
            chk("imm_no_req", 32'(bus.mem_req), 32'd0);
            chk("imm_valid",  32'(bus.resp_valid), 32'd1);
            chk("imm_err",    32'(bus.resp_err), 32'd1);
            chk("imm_rdata",  bus.resp_rdata, 32'h0);
        end else begin
            chk("mem_req",   32'(bus.mem_req), 32'd1);
            chk("mem_we",    32'(bus.mem_we), 32'(st));
            chk("mem_addr",  bus.mem_addr, a & 32'hFFFF_FFFC);
            chk("mem_wmask", 32'(bus.mem_wmask), 32'(exp_mask(st, a, sz)));
            if (st) chk("mem_wdata", bus.mem_wdata, wd << (8 * a[1:0]));
            req_cnt = 0;
            got     = 1'b0;
            while (!got && cyc < 40) begin
                if (bus.mem_req) req_cnt++;
                if (bus.resp_valid) got = 1'b1;
                else begin
                    if (cyc == ack_at) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = rd;
                    end
                    step();
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    cyc++;
                end
            end
            exp_cyc = to ? TO + 1 : ack_at + 1;
            chk("resp_cycle", 32'(cyc), 32'(exp_cyc));
            chk("req_cycles", 32'(req_cnt), 32'(exp_cyc - 1));
            chk("resp_err",   32'(bus.resp_err), 32'(to));
            chk("resp_rdata", bus.resp_rdata, exp_rd);
        end
        step();
        chk("pulse_1cyc", 32'(bus.resp_valid), 32'd0);
        chk("ready_back", 32'(bus.req_ready), 32'd1);
        chk("rdata_hold", bus.resp_rdata, exp_rd);
    endtask

    logic [7:0] sz_tab [4];

    initial begin
        sz_tab = '{SZ_BYTE, SZ_HALF_WORD, SZ_WORD, 8'h5A};
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0;
        bus.req_addr  = '0;   bus.req_wdata = '0;  bus.req_size = '0; bus.req_sext = '0;
        bus.mem_ack   = 1'b0; bus.mem_rdata = '0;
        repeat (3) step();

        // reset state
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_req",   32'(bus.mem_req), 32'd0);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_err",   32'(bus.resp_err), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_addr",  bus.mem_addr, 32'h0);
        chk("rst_wmask", 32'(bus.mem_wmask), 32'd0);
        rst = 1'b0;
        step();

        // directed cases
        run_txn(1, 0, 32'h8000_0004, 32'h0, SZ_WORD, 2'b00, 3, 32'hDEAD_BEEF);
        run_txn(1, 0, 32'h8000_0003, 32'h0, SZ_BYTE, 2'b01, 2, 32'h8011_2233);
        run_txn(1, 0, 32'h8000_0003, 32'h0, SZ_BYTE, 2'b00, 1, 32'h8011_2233);
        run_txn(0, 1, 32'h8000_0002, 32'h0000_ABCD, SZ_HALF_WORD, 2'b00, 2, 32'h1234_5678);
        run_txn(0, 1, 32'h8000_0001, 32'h1122_3344, SZ_WORD, 2'b00, 1, 32'h0);
        run_txn(1, 0, 32'h8000_0002, 32'h0, SZ_HALF_WORD, 2'b10, TO, 32'h8001_0000); // ack on last cycle
        run_txn(1, 1, 32'h8000_0000, 32'h0, SZ_WORD, 2'b00, 1, 32'h0);              // load+store conflict

        // timeout, then a late ack must not produce a response
        run_txn(1, 0, 32'h8000_0008, 32'h0, SZ_WORD, 2'b00, 0, 32'h0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("late_ack_valid", 32'(bus.resp_valid), 32'd0);
        step();
        chk("late_ack_valid2", 32'(bus.resp_valid), 32'd0);
        chk("late_ack_req",    32'(bus.mem_req), 32'd0);

        // request with neither load nor store is ignored
        wait_ready();
        drive_req(0, 0, 32'h8000_0000, 32'h0, SZ_WORD, 2'b00);
        chk("noop_req",   32'(bus.mem_req), 32'd0);
        chk("noop_ready", 32'(bus.req_ready), 32'd1);
        chk("noop_valid", 32'(bus.resp_valid), 32'd0);

        // reset while in ACCESS
        wait_ready();
        drive_req(1, 0, 32'h8000_0010, 32'h0, SZ_WORD, 2'b00);
        step();
        chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_req",   32'(bus.mem_req), 32'd0);
        chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("post_rst_valid", 32'(bus.resp_valid), 32'd0);
        step();
        chk("post_rst_valid2", 32'(bus.resp_valid), 32'd0);
        run_txn(1, 0, 32'h8000_0010, 32'h0, SZ_WORD, 2'b00, 2, 32'hCAFE_F00D);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int  r_op, r_ack, ack;
            bit  ld, st;
            r_op  = $urandom_range(0, 9);
            ld    = (r_op <= 5);
            st    = (r_op == 0) || (r_op > 5);
            r_ack = $urandom_range(0, 11);
            ack   = (r_ack == 0) ? 0 : (r_ack == 1) ? TO : $urandom_range(1, 4);
            run_txn(ld, st, 32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom,
                    sz_tab[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), ack, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // absolute watchdog
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
